// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle instruction-fetch controller: PC sequencing, imem requests, fault and halt handling
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] FAULT_VECTOR = 32'h0000_0080,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        fault,
  output logic        halted
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    UPDATE = 3'd3,
    FAULT  = 3'd4,
    HALTED = 3'd5
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        pc_en_q, pc_en_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  logic        halted_q, halted_d;

  logic [7:0]  wait_inc;
  logic [31:0] seq_pc;
  logic [31:0] target;

  assign wait_inc = wait_q + 8'd1;
  assign seq_pc   = pc_q + 32'd4;

  // Next-PC selection once execute completes: jump beats branch beats sequential.
  always_comb begin
    target = seq_pc;
    if (jump) begin
      target = jump_target;
    end else if (branch_taken) begin
      target = branch_target;
    end
  end

  // Next-state and registered-output computation. Outputs are registered, so each
  // one is set on the transition into the state that owns it. BOOT spends its first
  // post-reset cycle arming pc_en, then holds it for exactly one cycle.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pc_next_d     = pc_next_q;
    pc_en_d       = 1'b0;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fault_d       = fault_q;
    case (state_q)
      BOOT: begin
        if (!pc_en_q) begin
          pc_en_d   = 1'b1;
          pc_next_d = RESET_VECTOR;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          wait_d        = 8'd0;
          state_d       = EXEC;
        end else if (wait_inc >= MAX_WAIT_C) begin
          wait_d    = 8'd0;
          pc_en_d   = 1'b1;
          pc_next_d = FAULT_VECTOR;
          fault_d   = 1'b1;
          state_d   = FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end
      EXEC: begin
        if (exec_done) begin
          if (target[1:0] != 2'b00) begin
            pc_en_d   = 1'b1;
            pc_next_d = FAULT_VECTOR;
            fault_d   = 1'b1;
            state_d   = FAULT;
          end else if (halt) begin
            state_d = HALTED;
          end else begin
            pc_en_d   = 1'b1;
            pc_next_d = target;
            state_d   = UPDATE;
          end
        end
      end
      UPDATE: state_d = FETCH;
      FAULT:  state_d = FETCH;
      HALTED: state_d = HALTED;
      default: state_d = BOOT;
    endcase
    imem_req_d = (state_d == FETCH);
    halted_d   = (state_d == HALTED);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q       <= BOOT;
      wait_q        <= 8'd0;
      pc_next_q     <= 32'd0;
      pc_en_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      pc_next_q     <= pc_next_d;
      pc_en_q       <= pc_en_d;
      imem_req_q    <= imem_req_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      halted_q      <= halted_d;
    end
  end

  assign pc_next     = pc_next_q;
  assign pc_en       = pc_en_q;
  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_req_q ? pc_q : 32'd0;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam int EV_REQ   = 0;
  localparam int EV_INSTR = 1;
  localparam int EV_PC    = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic        flt;
  } ev_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] pc_reg = 32'h0000_0F00;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        halt = 1'b0;
  logic        fault;
  logic        halted;

  int   checks = 0;
  int   errors = 0;
  ev_t  sb[$];
  logic req_prev = 1'b0;
  logic exp_fault = 1'b0;

  fetch_sequencer dut (
    .Clk(Clk), .Rst(Rst), .pc_q(pc_reg), .pc_next(pc_next), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .halt(halt), .fault(fault), .halted(halted)
  );

  always #5 Clk = ~Clk;

  // PC register owned by the environment
  always @(posedge Clk) if (pc_en) pc_reg <= pc_next;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] data, input logic flt);
    ev_t e;
    e.kind = kind; e.data = data; e.flt = flt;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [31:0] data, input logic flt);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %h fault %0b, expected no event", kind, data, flt);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.data !== data || e.flt !== flt) begin
        errors++;
        $display("FAIL event: got kind %0d data %h fault %0b, expected kind %0d data %h fault %0b",
                 kind, data, flt, e.kind, e.data, e.flt);
      end
    end
  endtask

  // Monitor: every visible DUT event is matched against the head of the scoreboard
  always @(negedge Clk) begin
    if (Rst) begin
      if (imem_req && !req_prev) pop_cmp(EV_REQ, imem_addr, fault);
      if (instr_valid) pop_cmp(EV_INSTR, instr, fault);
      if (pc_en) pop_cmp(EV_PC, pc_next, fault);
    end
    req_prev = imem_req;
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 100) begin tick(); n++; end
    if (n >= 100) check("wait_imem_req_timeout", 32'd0, 32'd1);
  endtask

  // Fetch at addr, acknowledged in FETCH cycle lat with word data
  task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] data);
    push(EV_REQ, addr, exp_fault);
    push(EV_INSTR, data, exp_fault);
    wait_req();
    repeat (lat - 1) tick();
    imem_ack = 1'b1; imem_rdata = data;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
  endtask

  // exec_done in EXEC cycle dly; exp_pc < 0 style handled by push_pc flag
  task automatic exec(input int dly, input logic j, input logic [31:0] jt, input logic b,
                      input logic [31:0] bt, input logic h, input logic push_pc,
                      input logic [31:0] exp_pc);
    if (push_pc) push(EV_PC, exp_pc, exp_fault);
    repeat (dly - 1) tick();
    exec_done = 1'b1; jump = j; jump_target = jt; branch_taken = b; branch_target = bt; halt = h;
    tick();
    exec_done = 1'b0; jump = 1'b0; branch_taken = 1'b0; halt = 1'b0;
  endtask

  initial begin : stim
    int n;
    int bad;
    // reset state
    repeat (3) tick();
    @(negedge Clk);
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check("rst_pc_next", pc_next, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_outs", {28'd0, instr_valid, fault, halted, 1'b0}, 32'd0);
    @(posedge Clk); #1;
    push(EV_PC, 32'h0000_0000, 1'b0);
    Rst = 1'b1;

    // sequential fetches 0, 4, 8
    fetch(32'h0, 1, 32'h1111_0000);
    exec(1, 0, 0, 0, 0, 0, 1, 32'h4);
    fetch(32'h4, 1, 32'h1111_0004);
    exec(2, 0, 0, 0, 0, 0, 1, 32'h8);
    fetch(32'h8, 1, 32'h1111_0008);
    exec(1, 0, 0, 1, 32'h10, 0, 1, 32'h10);
    // jump beats branch
    fetch(32'h10, 2, 32'h2222_0010);
    exec(1, 1, 32'h100, 1, 32'h40, 0, 1, 32'h100);
    fetch(32'h100, 1, 32'h2222_0100);
    exec(3, 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'hFFFF_FFFC);
    // sequential wrap
    fetch(32'hFFFF_FFFC, 1, 32'h3333_FFFC);
    exec(1, 0, 0, 0, 0, 0, 1, 32'h0);
    // misaligned branch target -> fault vector
    fetch(32'h0, 1, 32'h4444_0000);
    exp_fault = 1'b1;
    exec(1, 0, 0, 1, 32'h42, 0, 1, 32'h80);
    check("misaligned_fault", {31'd0, fault}, 32'd1);
    fetch(32'h80, 1, 32'h4444_0080);
    exec(1, 0, 0, 0, 0, 0, 1, 32'h84);

    // reset while waiting on ack
    push(EV_REQ, 32'h84, 1'b1);
    wait_req();
    repeat (3) tick();
    Rst = 1'b0;
    tick();
    check("midrst_imem_req", {31'd0, imem_req}, 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_fault", {31'd0, fault}, 32'd0);
    check("midrst_pc_en", {31'd0, pc_en}, 32'd0);
    exp_fault = 1'b0;
    push(EV_PC, 32'h0, 1'b0);
    Rst = 1'b1;
    fetch(32'h0, 1, 32'h5555_0000);
    exec(1, 1, 32'h20, 0, 0, 0, 1, 32'h20);

    // timeout after MAX_WAIT cycles without ack
    push(EV_REQ, 32'h20, 1'b0);
    push(EV_PC, 32'h80, 1'b1);
    wait_req();
    n = 0;
    while (!pc_en && n < 40) begin tick(); n++; end
    check("timeout_cycles", n, 32'd15);
    exp_fault = 1'b1;
    fetch(32'h80, 1, 32'h6666_0080);
    exec(1, 1, 32'h20, 0, 0, 0, 1, 32'h20);
    // ack in cycle 15 wins over the timeout
    fetch(32'h20, 15, 32'h7777_0020);
    exec(1, 0, 0, 0, 0, 0, 1, 32'h24);
    // halt at exec_done
    fetch(32'h24, 1, 32'h8888_0024);
    exec(2, 0, 0, 0, 0, 1, 0, 32'h0);
    check("halted", {31'd0, halted}, 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req || pc_en || !halted) bad++;
      tick();
    end
    check("halted_quiet", bad, 32'd0);
    repeat (2) tick();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
